hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// data-memory wait freeze with timeout, post-reset pipeline flush.
module hazard_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MAX_WAIT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1_D,
  input  logic [4:0]  Rs2_D,
  input  logic [4:0]  Rs1_E,
  input  logic [4:0]  Rs2_E,
  input  logic [4:0]  Rd_E,
  input  logic [4:0]  Rd_M,
  input  logic [4:0]  Rd_W,
  input  logic [1:0]  ResultSrc_E,
  input  logic        RegWrite_M,
  input  logic        RegWrite_W,
  input  logic        PCSrc_E,
  input  logic        MemBusy_M,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Stall_E,
  output logic        Stall_M,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic        Flush_W,
  output logic [1:0]  ForwardA_E,
  output logic [1:0]  ForwardB_E,
  output logic        MemTimeout,
  output logic [31:0] StallCount
);

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [7:0] INIT_END = 8'(INIT_CYCLES - 1);
  localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        lw_stall, any_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWrite_M && Rd_M != 5'd0 && Rd_M == rs)      return 2'b10;
    else if (RegWrite_W && Rd_W != 5'd0 && Rd_W == rs) return 2'b01;
    else                                               return 2'b00;
  endfunction

  assign ForwardA_E = fwd_sel(Rs1_E);
  assign ForwardB_E = fwd_sel(Rs2_E);
  assign lw_stall   = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                      ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  // Control outputs follow the current state and this cycle's inputs, so a
  // memory stall freezes the pipe in the very cycle it is raised.
  always_comb begin
    Stall_F = 1'b0; Stall_D = 1'b0; Stall_E = 1'b0; Stall_M = 1'b0;
    Flush_D = 1'b0; Flush_E = 1'b0; Flush_W = 1'b0;
    case (state_q)
      INIT: begin
        Flush_D = 1'b1; Flush_E = 1'b1;
      end
      ERROR: begin
        Stall_F = 1'b1; Stall_D = 1'b1; Stall_E = 1'b1; Stall_M = 1'b1;
        Flush_W = 1'b1;
      end
      default: begin
        if (MemBusy_M) begin
          Stall_F = 1'b1; Stall_D = 1'b1; Stall_E = 1'b1; Stall_M = 1'b1;
          Flush_W = 1'b1;
        end else if (PCSrc_E) begin
          Flush_D = 1'b1; Flush_E = 1'b1;
        end else if (lw_stall) begin
          Stall_F = 1'b1; Stall_D = 1'b1; Flush_E = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q >= INIT_END) state_d = RUN;
      end
      RUN: begin
        if (MemBusy_M) begin
          state_d = MEM_WAIT;
          cnt_d   = 8'd1;
        end
      end
      MEM_WAIT: begin
        // cnt_q counts busy cycles already tolerated in this wait
        if (!MemBusy_M)          state_d = RUN;
        else if (cnt_q == MAX_W) state_d = ERROR;
        else                     cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = ERROR;
    endcase
  end

  assign timeout_d   = (state_d == ERROR);
  assign any_stall   = Stall_F | Stall_D | Stall_E | Stall_M;
  assign stall_cnt_d = (any_stall && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      cnt_q       <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemTimeout = timeout_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (MAX_WAIT 255 and 3) share
// stimulus; expectations come from a cycle-level behavioural model.
module tb_hazard_ctrl;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] rsrc;
    logic       rw_m, rw_w, pcsrc, busy;
  } inp_t;

  typedef struct {
    logic [6:0]  ctl;   // {Stall_F,Stall_D,Stall_E,Stall_M,Flush_D,Flush_E,Flush_W}
    logic [1:0]  fa, fb;
    logic        to;
    logic [31:0] sc;
  } exp_t;

  typedef struct {
    int          init_left;
    bit          err;
    int          busy_run;
    logic [31:0] sc;
  } model_t;

  localparam int INIT_N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  inp_t cur;
  logic        rst_s;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]  rsrc;
  logic        rw_m, rw_w, pcsrc, busy;
  assign rst_s = cur.rst_n; assign rs1_d = cur.rs1_d; assign rs2_d = cur.rs2_d;
  assign rs1_e = cur.rs1_e; assign rs2_e = cur.rs2_e; assign rd_e = cur.rd_e;
  assign rd_m  = cur.rd_m;  assign rd_w  = cur.rd_w;  assign rsrc = cur.rsrc;
  assign rw_m  = cur.rw_m;  assign rw_w  = cur.rw_w;  assign pcsrc = cur.pcsrc;
  assign busy  = cur.busy;

  logic [6:0]  ctl_a, ctl_b;
  logic [1:0]  fa_a, fb_a, fa_b, fb_b;
  logic        to_a, to_b;
  logic [31:0] sc_a, sc_b;

  hazard_ctrl #(.INIT_CYCLES(INIT_N), .MAX_WAIT(255)) dut_a (
    .clk(clk), .reset(rst_s),
    .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
    .Rd_E(rd_e), .Rd_M(rd_m), .Rd_W(rd_w), .ResultSrc_E(rsrc),
    .RegWrite_M(rw_m), .RegWrite_W(rw_w), .PCSrc_E(pcsrc), .MemBusy_M(busy),
    .Stall_F(ctl_a[6]), .Stall_D(ctl_a[5]), .Stall_E(ctl_a[4]), .Stall_M(ctl_a[3]),
    .Flush_D(ctl_a[2]), .Flush_E(ctl_a[1]), .Flush_W(ctl_a[0]),
    .ForwardA_E(fa_a), .ForwardB_E(fb_a), .MemTimeout(to_a), .StallCount(sc_a)
  );

  hazard_ctrl #(.INIT_CYCLES(INIT_N), .MAX_WAIT(3)) dut_b (
    .clk(clk), .reset(rst_s),
    .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
    .Rd_E(rd_e), .Rd_M(rd_m), .Rd_W(rd_w), .ResultSrc_E(rsrc),
    .RegWrite_M(rw_m), .RegWrite_W(rw_w), .PCSrc_E(pcsrc), .MemBusy_M(busy),
    .Stall_F(ctl_b[6]), .Stall_D(ctl_b[5]), .Stall_E(ctl_b[4]), .Stall_M(ctl_b[3]),
    .Flush_D(ctl_b[2]), .Flush_E(ctl_b[1]), .Flush_W(ctl_b[0]),
    .ForwardA_E(fa_b), .ForwardB_E(fb_b), .MemTimeout(to_b), .StallCount(sc_b)
  );

  int total = 0;
  int bad   = 0;
  exp_t   qa[$], qb[$];
  model_t ma, mb;

  function automatic model_t m_reset();
    model_t m;
    m.init_left = INIT_N; m.err = 1'b0; m.busy_run = 0; m.sc = 32'd0;
    return m;
  endfunction

  function automatic logic [1:0] m_fwd(inp_t i, logic [4:0] rs);
    if (i.rw_m && i.rd_m != 0 && i.rd_m == rs) return 2'b10;
    if (i.rw_w && i.rd_w != 0 && i.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected visible behaviour for the current cycle, by priority of the rules.
  function automatic exp_t m_out(model_t m, inp_t i);
    exp_t e;
    bit lw;
    lw = (i.rsrc == 2'b01) && (i.rd_e != 0) && (i.rd_e == i.rs1_d || i.rd_e == i.rs2_d);
    if (!i.rst_n || m.init_left > 0) e.ctl = 7'b0000110;
    else if (m.err || i.busy)        e.ctl = 7'b1111001;
    else if (i.pcsrc)                e.ctl = 7'b0000110;
    else if (lw)                     e.ctl = 7'b1100010;
    else                             e.ctl = 7'b0000000;
    e.fa = m_fwd(i, i.rs1_e);
    e.fb = m_fwd(i, i.rs2_e);
    e.to = m.err;
    e.sc = m.sc;
    return e;
  endfunction

  // Advance the model over one rising edge seen with inputs i.
  function automatic model_t m_edge(model_t m, inp_t i, int maxw);
    exp_t e;
    if (!i.rst_n) return m;
    e = m_out(m, i);
    if (|e.ctl[6:3] && m.sc != 32'hFFFF_FFFF) m.sc = m.sc + 1;
    if (m.init_left > 0) m.init_left--;
    else if (!m.err) begin
      if (i.busy) begin
        m.busy_run++;
        if (m.busy_run > maxw) m.err = 1'b1;
      end else m.busy_run = 0;
    end
    return m;
  endfunction

  function automatic inp_t idle();
    inp_t n;
    n = '{default: '0};
    n.rst_n = 1'b1;
    return n;
  endfunction

  function automatic inp_t rnd();
    inp_t n;
    n.rst_n = ($urandom_range(0, 79) != 0);
    n.rs1_d = 5'($urandom_range(0, 3)); n.rs2_d = 5'($urandom_range(0, 3));
    n.rs1_e = 5'($urandom_range(0, 3)); n.rs2_e = 5'($urandom_range(0, 3));
    n.rd_e  = 5'($urandom_range(0, 3)); n.rd_m  = 5'($urandom_range(0, 3));
    n.rd_w  = 5'($urandom_range(0, 3));
    n.rsrc  = 2'($urandom_range(0, 3));
    n.rw_m  = 1'($urandom_range(0, 1)); n.rw_w = 1'($urandom_range(0, 1));
    n.pcsrc = ($urandom_range(0, 5) == 0);
    n.busy  = ($urandom_range(0, 4) == 0);
    return n;
  endfunction

  task automatic drive(input inp_t n);
    @(posedge clk);
    ma = m_edge(ma, cur, 255);
    mb = m_edge(mb, cur, 3);
    #1;
    cur = n;
    if (!n.rst_n) begin
      ma = m_reset();
      mb = m_reset();
    end
    qa.push_back(m_out(ma, n));
    qb.push_back(m_out(mb, n));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; consume one expectation per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_ctl", 32'(ctl_a), 32'(e.ctl));
      chk("a_fwd", {28'd0, fa_a, fb_a}, {28'd0, e.fa, e.fb});
      chk("a_timeout", 32'(to_a), 32'(e.to));
      chk("a_stallcount", sc_a, e.sc);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_ctl", 32'(ctl_b), 32'(e.ctl));
      chk("b_fwd", {28'd0, fa_b, fb_b}, {28'd0, e.fa, e.fb});
      chk("b_timeout", 32'(to_b), 32'(e.to));
      chk("b_stallcount", sc_b, e.sc);
    end
  end

  initial begin
    inp_t n;
    cur = idle();
    cur.rst_n = 1'b0;
    ma = m_reset();
    mb = m_reset();

    n = idle(); n.rst_n = 1'b0; n.busy = 1'b1;
    repeat (3) drive(n);                        // reset held, busy ignored
    n = idle();
    repeat (4) drive(n);                        // 2 init flush cycles, then run
    n = idle(); n.rsrc = 2'b01; n.rd_e = 5'd5; n.rs2_d = 5'd5;
    drive(n);                                   // load-use stall
    drive(idle());
    n = idle(); n.rs1_e = 5'd3; n.rd_m = 5'd3; n.rw_m = 1'b1; n.rd_w = 5'd3; n.rw_w = 1'b1;
    drive(n);                                   // memory wins over writeback
    n.rs1_e = 5'd0; n.rd_m = 5'd0;
    drive(n);                                   // x0 never forwarded
    n = idle(); n.pcsrc = 1'b1; n.rsrc = 2'b01; n.rd_e = 5'd7; n.rs1_d = 5'd7;
    drive(n);                                   // branch beats load-use
    n = idle(); n.busy = 1'b1;
    repeat (4) drive(n);                        // a recovers, b times out
    repeat (3) drive(idle());
    n = idle(); n.pcsrc = 1'b1;
    drive(n);
    n = idle(); n.rst_n = 1'b0;
    drive(n);                                   // reset clears timeout and count
    repeat (3) drive(idle());
    repeat (800) drive(rnd());
    drive(idle());

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
